// File: rtl/ym3438_pkg.sv
// Shared constants and types for the YM3438 LFO/phase register feeder.
// Slot ordering: slot = op*6 + ch, 24 slots per sample frame.
package ym3438_pkg;

    localparam int NUM_CH    = 6;
    localparam int NUM_SLOTS = 24;
    localparam logic [4:0] LAST_SLOT = 5'(NUM_SLOTS - 1);

    localparam logic [7:0] REG_TEST    = 8'h21;
    localparam logic [7:0] REG_LFO     = 8'h22;
    localparam logic [7:0] REG_MODE    = 8'h27;
    localparam logic [7:0] REG_FNUM_LO = 8'hA0;
    localparam logic [7:0] REG_FNUM_HI = 8'hA4;
    localparam logic [7:0] REG_CH3_LO  = 8'hA8;
    localparam logic [7:0] REG_CH3_HI  = 8'hAC;
    localparam logic [7:0] REG_PMS_AMS = 8'hB4;

    typedef struct packed {
        logic [1:0]  ams;
        logic [2:0]  pms;
        logic [2:0]  block;
        logic [10:0] fnum;
    } chan_regs_t;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] ch;
    } slot_pos_t;

    function automatic slot_pos_t slot_pos(input logic [4:0] s);
        slot_pos_t p;
        p.ch = 3'(s % 5'd6);
        p.op = 2'(s / 5'd6);
        return p;
    endfunction

endpackage

// File: rtl/ym3438_lfo_regs_chan_file.sv
// Six-entry per-channel {ams, pms, block, fnum} store with one write port and
// one combinational read port; a same-edge read sees the pre-write contents.
module ym3438_lfo_regs_chan_file
    import ym3438_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_freq,
    input  logic        wr_mod,
    input  logic [2:0]  wr_ch,
    input  logic [2:0]  wr_block,
    input  logic [10:0] wr_fnum,
    input  logic [2:0]  wr_pms,
    input  logic [1:0]  wr_ams,
    input  logic [2:0]  rd_ch,
    output chan_regs_t  rd_data
);

    chan_regs_t regs [NUM_CH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) regs[i] <= '0;
        end else begin
            // block and fnum land together so the pair is never seen half-updated
            if (wr_freq) begin
                regs[wr_ch].block <= wr_block;
                regs[wr_ch].fnum  <= wr_fnum;
            end
            if (wr_mod) begin
                regs[wr_ch].ams <= wr_ams;
                regs[wr_ch].pms <= wr_pms;
            end
        end
    end

    assign rd_data = regs[rd_ch];

endmodule

// File: rtl/ym3438_lfo_regs.sv
// CPU write capture and slot-ordered replay of fnum/block/pms/ams for the LFO path.
// Optional: define YM3438_CH3_SPECIAL_EN for per-operator channel-3 frequencies.
module ym3438_lfo_regs
    import ym3438_pkg::*;
(
    input  logic        MCLK,
    input  logic        IC,
    input  logic        c1,
    input  logic        wr_en,
    input  logic [8:0]  wr_addr,
    input  logic [7:0]  wr_data,
    output logic [3:0]  lfo,
    output logic [7:0]  reg_21,
    output logic [10:0] fnum,
    output logic [2:0]  block,
    output logic [2:0]  pms,
    output logic [1:0]  ams,
    output logic [4:0]  slot,
    output logic        fsm_sel23
);

    logic       bank;
    logic [7:0] ra;
    logic [1:0] idx;
    logic       idx_ok;
    logic [2:0] wr_ch;
    logic       hit_fnum_lo, hit_fnum_hi, hit_pms;

    logic [5:0]  latch;
    logic [1:0]  mode;
    logic [4:0]  slot_nxt;
    slot_pos_t   nxt_pos;
    chan_regs_t  rd_entry;
    logic [10:0] sel_fnum;
    logic [2:0]  sel_block;

    assign bank   = wr_addr[8];
    assign ra     = wr_addr[7:0];
    assign idx    = ra[1:0];
    assign idx_ok = (idx != 2'd3);
    assign wr_ch  = bank ? ({1'b0, idx} + 3'd3) : {1'b0, idx};

    assign hit_fnum_lo = wr_en && idx_ok && ((ra & 8'hFC) == REG_FNUM_LO);
    assign hit_fnum_hi = wr_en && idx_ok && ((ra & 8'hFC) == REG_FNUM_HI);
    assign hit_pms     = wr_en && idx_ok && ((ra & 8'hFC) == REG_PMS_AMS);

    assign slot_nxt  = (slot == LAST_SLOT) ? 5'd0 : slot + 5'd1;
    assign nxt_pos   = slot_pos(slot_nxt);
    assign fsm_sel23 = (slot == LAST_SLOT);

    ym3438_lfo_regs_chan_file u_chan_file (
        .clk      (MCLK),
        .rst      (IC),
        .wr_freq  (hit_fnum_lo),
        .wr_mod   (hit_pms),
        .wr_ch    (wr_ch),
        .wr_block (latch[5:3]),
        .wr_fnum  ({latch[2:0], wr_data}),
        .wr_pms   (wr_data[2:0]),
        .wr_ams   (wr_data[5:4]),
        .rd_ch    (nxt_pos.ch),
        .rd_data  (rd_entry)
    );

`ifdef YM3438_CH3_SPECIAL_EN
    logic [5:0]  ch3_latch;
    logic [13:0] ch3_freq [0:2];
    logic [1:0]  ch3_op;
    logic        hit_ch3_lo, hit_ch3_hi;

    // A9/AD feed op0, AA/AE op1, A8/AC op2
    assign ch3_op     = (idx == 2'd0) ? 2'd2 : idx - 2'd1;
    assign hit_ch3_lo = wr_en && !bank && idx_ok && ((ra & 8'hFC) == REG_CH3_LO);
    assign hit_ch3_hi = wr_en && !bank && idx_ok && ((ra & 8'hFC) == REG_CH3_HI);

    always_ff @(posedge MCLK or posedge IC) begin
        if (IC) begin
            ch3_latch <= '0;
            for (int i = 0; i < 3; i++) ch3_freq[i] <= '0;
        end else begin
            if (hit_ch3_hi) ch3_latch <= wr_data[5:0];
            if (hit_ch3_lo) ch3_freq[ch3_op] <= {ch3_latch, wr_data};
        end
    end

    always_comb begin
        sel_fnum  = rd_entry.fnum;
        sel_block = rd_entry.block;
        if (mode != 2'd0 && nxt_pos.ch == 3'd2 && nxt_pos.op != 2'd3) begin
            sel_fnum  = ch3_freq[nxt_pos.op][10:0];
            sel_block = ch3_freq[nxt_pos.op][13:11];
        end
    end
`else
    logic unused_mode;
    assign unused_mode = ^{mode, nxt_pos.op};

    always_comb begin
        sel_fnum  = rd_entry.fnum;
        sel_block = rd_entry.block;
    end
`endif

    always_ff @(posedge MCLK or posedge IC) begin
        if (IC) begin
            reg_21 <= '0;
            lfo    <= '0;
            mode   <= '0;
            latch  <= '0;
            slot   <= '0;
            fnum   <= '0;
            block  <= '0;
            pms    <= '0;
            ams    <= '0;
        end else begin
            if (wr_en && !bank) begin
                case (ra)
                    REG_TEST: reg_21 <= wr_data;
                    REG_LFO:  lfo    <= wr_data[3:0];
                    REG_MODE: mode   <= wr_data[7:6];
                    default:  ;
                endcase
            end
            if (hit_fnum_hi) latch <= wr_data[5:0];
            // outputs move with the slot and reflect the slot being entered
            if (c1) begin
                slot  <= slot_nxt;
                fnum  <= sel_fnum;
                block <= sel_block;
                pms   <= rd_entry.pms;
                ams   <= rd_entry.ams;
            end
        end
    end

endmodule

// File: tb/tb_ym3438_lfo_regs.sv
// Directed bench for ym3438_lfo_regs; covers YM3438_CH3_SPECIAL_EN when defined.
module tb_ym3438_lfo_regs;

    logic        MCLK = 1'b0;
    logic        IC = 1'b1;
    logic        c1 = 1'b0;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [3:0]  lfo;
    logic [7:0]  reg_21;
    logic [10:0] fnum;
    logic [2:0]  block;
    logic [2:0]  pms;
    logic [1:0]  ams;
    logic [4:0]  slot;
    logic        fsm_sel23;

    int vectors = 0;
    int errors  = 0;
    int exp_slot = 0;

    ym3438_lfo_regs dut (
        .MCLK      (MCLK),
        .IC        (IC),
        .c1        (c1),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .lfo       (lfo),
        .reg_21    (reg_21),
        .fnum      (fnum),
        .block     (block),
        .pms       (pms),
        .ams       (ams),
        .slot      (slot),
        .fsm_sel23 (fsm_sel23)
    );

    always #5 MCLK = ~MCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        @(negedge MCLK);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge MCLK);
        wr_en = 1'b0;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge MCLK);
            c1 = 1'b1;
            @(negedge MCLK);
            c1 = 1'b0;
            exp_slot = (exp_slot + 1) % 24;
        end
    endtask

    task automatic goto_slot(input int s);
        int n;
        n = (s - exp_slot + 24) % 24;
        if (n == 0) n = 24;
        advance(n);
    endtask

    task automatic test_reset;
        wr(9'h022, 8'h0F);
        wr(9'h021, 8'hFF);
        wr(9'h0A5, 8'h3F);
        wr(9'h0A1, 8'hAA);
        wr(9'h0B5, 8'h37);
        goto_slot(7);
        @(negedge MCLK);
        #3 IC = 1'b1;
        #1;
        vectors++;
        if ({slot, fnum, block, pms, ams, lfo, reg_21, fsm_sel23} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: slot=%0d fnum=%h block=%0d pms=%0d ams=%0d lfo=%h reg_21=%h sel23=%b, required all 0",
                     slot, fnum, block, pms, ams, lfo, reg_21, fsm_sel23);
        end
        @(negedge MCLK);
        IC = 1'b0;
        exp_slot = 0;
        begin
            int hits = 0;
            int hit_slot = -1;
            for (int i = 0; i < 24; i++) begin
                advance(1);
                vectors++;
                if (slot !== 5'(exp_slot)) begin
                    errors++;
                    $display("FAIL slot_count: slot=%0d required %0d", slot, exp_slot);
                end
                if (fsm_sel23) begin hits++; hit_slot = int'(slot); end
                vectors++;
                if (fnum !== 11'h0 || pms !== 3'h0) begin
                    errors++;
                    $display("FAIL reset_cleared_chan: slot=%0d fnum=%h pms=%0d required 0", slot, fnum, pms);
                end
            end
            vectors++;
            if (hits !== 1 || hit_slot !== 23) begin
                errors++;
                $display("FAIL sel23_once: hits=%0d at slot %0d, required 1 at 23", hits, hit_slot);
            end
        end
    endtask

    task automatic test_fnum_write;
        wr(9'h0A4, 8'h22);
        wr(9'h0A0, 8'h69);
        for (int s = 0; s < 24; s++) begin
            goto_slot(s);
            vectors++;
            if ((s % 6) == 0) begin
                if (fnum !== 11'h269 || block !== 3'd4) begin
                    errors++;
                    $display("FAIL ch0_freq: slot %0d fnum=%h block=%0d, required 269/4", s, fnum, block);
                end
            end else if (fnum !== 11'h0 || block !== 3'd0) begin
                errors++;
                $display("FAIL other_ch_freq: slot %0d fnum=%h block=%0d, required 0/0", s, fnum, block);
            end
        end
    endtask

    task automatic test_pms_ams;
        wr(9'h1B5, 8'h37);
        wr(9'h0B7, 8'hFF);
        wr(9'h1B7, 8'hFF);
        wr(9'h0A3, 8'hFF);
        wr(9'h1A7, 8'hFF);
        wr(9'h0A3, 8'h55);
        for (int s = 0; s < 24; s++) begin
            goto_slot(s);
            vectors++;
            if ((s % 6) == 4) begin
                if (ams !== 2'd3 || pms !== 3'd7) begin
                    errors++;
                    $display("FAIL ch4_pms_ams: slot %0d ams=%0d pms=%0d, required 3/7", s, ams, pms);
                end
            end else if (ams !== 2'd0 || pms !== 3'd0) begin
                errors++;
                $display("FAIL other_pms_ams: slot %0d ams=%0d pms=%0d, required 0/0", s, ams, pms);
            end
            vectors++;
            if ((s % 6) == 0 && (fnum !== 11'h269 || block !== 3'd4)) begin
                errors++;
                $display("FAIL ignored_addr_freq: slot %0d fnum=%h block=%0d, required 269/4", s, fnum, block);
            end else if ((s % 6) != 0 && fnum !== 11'h0) begin
                errors++;
                $display("FAIL ignored_addr_other: slot %0d fnum=%h, required 0", s, fnum);
            end
        end
    endtask

    task automatic test_latch_reuse;
        goto_slot(0);
        wr(9'h0A4, 8'h05);
        wr(9'h0A0, 8'h10);
        vectors++;
        if (fnum !== 11'h269 || block !== 3'd4) begin
            errors++;
            $display("FAIL shown_slot_hold: fnum=%h block=%0d, required 269/4", fnum, block);
        end
        goto_slot(6);
        vectors++;
        if (fnum !== 11'h510 || block !== 3'd0) begin
            errors++;
            $display("FAIL next_slot_update: fnum=%h block=%0d, required 510/0", fnum, block);
        end
        wr(9'h0A0, 8'h20);
        goto_slot(12);
        vectors++;
        if (fnum !== 11'h520 || block !== 3'd0) begin
            errors++;
            $display("FAIL latch_reuse: fnum=%h block=%0d, required 520/0", fnum, block);
        end
        goto_slot(23);
        @(negedge MCLK);
        c1 = 1'b1; wr_en = 1'b1; wr_addr = 9'h0A0; wr_data = 8'h33;
        @(negedge MCLK);
        c1 = 1'b0; wr_en = 1'b0;
        exp_slot = 0;
        vectors++;
        if (slot !== 5'd0 || fnum !== 11'h520) begin
            errors++;
            $display("FAIL coincident_read: slot=%0d fnum=%h, required 0/520", slot, fnum);
        end
        goto_slot(6);
        vectors++;
        if (fnum !== 11'h533 || block !== 3'd0) begin
            errors++;
            $display("FAIL coincident_write: fnum=%h block=%0d, required 533/0", fnum, block);
        end
    endtask

    task automatic test_lfo_regs;
        wr(9'h022, 8'h0B);
        wr(9'h021, 8'h02);
        vectors++;
        if (lfo !== 4'hB || reg_21 !== 8'h02) begin
            errors++;
            $display("FAIL lfo_reg21: lfo=%h reg_21=%h, required B/02", lfo, reg_21);
        end
        wr(9'h122, 8'h05);
        wr(9'h121, 8'h77);
        vectors++;
        if (lfo !== 4'hB || reg_21 !== 8'h02) begin
            errors++;
            $display("FAIL bank1_ignored: lfo=%h reg_21=%h, required B/02", lfo, reg_21);
        end
    endtask

    task automatic test_ch3_mode;
        wr(9'h0A6, 8'h0F);
        wr(9'h0A2, 8'h11);
        wr(9'h027, 8'h40);
        wr(9'h0AD, 8'h1A);
        wr(9'h0A9, 8'h34);
        goto_slot(2);
        vectors++;
`ifdef YM3438_CH3_SPECIAL_EN
        if (fnum !== 11'h234 || block !== 3'd3) begin
            errors++;
            $display("FAIL ch3_op0: fnum=%h block=%0d, required 234/3", fnum, block);
        end
`else
        if (fnum !== 11'h711 || block !== 3'd1) begin
            errors++;
            $display("FAIL ch3_mode_ignored: fnum=%h block=%0d, required 711/1", fnum, block);
        end
`endif
        goto_slot(20);
        vectors++;
        if (fnum !== 11'h711 || block !== 3'd1) begin
            errors++;
            $display("FAIL ch3_op3_normal: fnum=%h block=%0d, required 711/1", fnum, block);
        end
        wr(9'h027, 8'h00);
        goto_slot(2);
        vectors++;
        if (fnum !== 11'h711 || block !== 3'd1) begin
            errors++;
            $display("FAIL ch3_revert: fnum=%h block=%0d, required 711/1", fnum, block);
        end
    endtask

    initial begin
        repeat (3) @(negedge MCLK);
        IC = 1'b0;
        test_reset;
        test_fnum_write;
        test_pms_ams;
        test_latch_reuse;
        test_lfo_regs;
        test_ch3_mode;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
